stepmtr_move_ctrl: RTL and testbench

Move controller sitting directly upstream of the stepper phase sequencer. It accepts move commands (direction plus step count) over a valid/ready handshake. It emits one-clock step strobes and a direction level at a rate bounded by MAX_HZ, with an optional symmetric linear acceleration ramp. It also tracks absolute position. The downstream sequencer advances one phase per `step` strobe in the sense given by `dir`.

---
 rtl/stepmtr_move_ctrl.sv | 137 +++++++++++++
 tb/tb_stepmtr_move_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stepmtr_move_ctrl.sv
// Stepper move controller: turns (dir, count) commands into step strobes with optional linear ramp (STEPMTR_RAMP_EN).
// Latency: first step I(1) cycles after acceptance; done one cycle after the last step, ready one cycle later.
// Backpressure: cmd_ready is high only in IDLE; a held command is accepted on the first IDLE cycle.
module stepmtr_move_ctrl #(
    parameter int CLK_HZ    = 12_000_000,
    parameter int MAX_HZ    = 400,
    parameter int MIN_HZ    = 100,
    parameter int ACC_STEPS = 16,
    parameter int POS_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [15:0]      cmd_steps,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
);

    localparam int P_MIN   = CLK_HZ / MAX_HZ;
    localparam int P_START = CLK_HZ / MIN_HZ;
    localparam int CNT_W   = $clog2(P_START + 1);

    // Strobes must never be adjacent and the ramp must have at least one step.
    if (MIN_HZ > MAX_HZ || ACC_STEPS < 1 || P_MIN < 2) begin : g_cfg_err
        $error("stepmtr_move_ctrl: invalid rate configuration");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        rem_q;
    logic               dir_q;
    logic [POS_W-1:0]   pos_q;

    logic               accept;
    logic               expire;
    logic [CNT_W-1:0]   ivl_first;
    logic [CNT_W-1:0]   ivl_reload;

    assign accept = (state_q == S_IDLE) && cmd_valid;
    assign expire = (state_q == S_RUN) && (cnt_q == CNT_W'(1)) && !abort;

`ifdef STEPMTR_RAMP_EN
    localparam int DELTA = (P_START - P_MIN) / ACC_STEPS;
    localparam int UP_W  = $clog2(ACC_STEPS + 1);

    // up_q tracks min(k-1, ACC_STEPS) for the step currently being timed.
    logic [UP_W-1:0]    up_q;
    logic [UP_W-1:0]    up_nxt;
    logic [UP_W-1:0]    ramp_m;
    logic [15:0]        rem_left;

    always_comb begin
        up_nxt   = (up_q == UP_W'(ACC_STEPS)) ? up_q : up_q + UP_W'(1);
        // Steps that will still follow the next one: N-(k+1).
        rem_left = rem_q - 16'd2;
        ramp_m   = (rem_left < 16'(up_nxt)) ? rem_left[UP_W-1:0] : up_nxt;
        ivl_first  = CNT_W'(P_START);
        ivl_reload = CNT_W'(P_START) - CNT_W'(DELTA) * CNT_W'(ramp_m);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q <= '0;
        end else if (accept) begin
            up_q <= '0;
        end else if (expire) begin
            up_q <= up_nxt;
        end
    end
`else
    assign ivl_first  = CNT_W'(P_MIN);
    assign ivl_reload = CNT_W'(P_MIN);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_steps == 16'd0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_FIN;
                end else if (expire && rem_q == 16'd1) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dir_q <= cmd_dir;
                rem_q <= cmd_steps;
                cnt_q <= ivl_first;
            end else if (expire) begin
                rem_q <= rem_q - 16'd1;
                cnt_q <= ivl_reload;
                pos_q <= dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            end else if (state_q == S_RUN && !abort) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign step      = expire;
    assign dir       = dir_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_FIN);
    assign position  = pos_q;

endmodule

// File: tb/tb_stepmtr_move_ctrl.sv
// Bench for stepmtr_move_ctrl at CLK_HZ=1000, MIN_HZ=100, MAX_HZ=500, ACC_STEPS=4 (P_START=10, P_MIN=2, DELTA=2).
module tb_stepmtr_move_ctrl;

`ifdef STEPMTR_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic        abort;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic [15:0] position;

    stepmtr_move_ctrl #(
        .CLK_HZ    (1000),
        .MAX_HZ    (500),
        .MIN_HZ    (100),
        .ACC_STEPS (4),
        .POS_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .step      (step),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_pos = 16'd0;

    typedef struct {
        logic        d;
        int          n;
        int          abort_k;   // step index on whose cycle abort is raised, 0 = none
        logic [15:0] pos_after;
        int          done_at;   // cycles after acceptance
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Interval before step k of an n-step move.
    function automatic int exp_ivl(input int k, input int n);
        int m;
        m = k - 1;
        if (m > 4) m = 4;
        if (n - k < m) m = n - k;
        return RAMP ? 10 - 2 * m : 2;
    endfunction

    task automatic run_move(input vec_t v, input string tag);
        int t_step[64];
        int tt;
        int issued;
        int abort_t;
        int kexp;
        int e_step, e_busy, e_done, e_rdy, e_dir, e_pos, nsteps;
        logic [15:0] model;
        logic want_step;
        tt = 0;
        for (int k = 1; k <= v.n && k < 64; k++) begin
            tt += exp_ivl(k, v.n);
            t_step[k] = tt;
        end
        issued  = (v.abort_k > 0) ? v.abort_k - 1 : v.n;
        abort_t = (v.abort_k > 0) ? t_step[v.abort_k] : -1;
        model   = exp_pos;
        e_step = 0; e_busy = 0; e_done = 0; e_rdy = 0; e_dir = 0; e_pos = 0; nsteps = 0;
        kexp = 1;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_dir   = v.d;
        cmd_steps = v.n[15:0];
        @(negedge clk);
        check({tag, ":accept_rdy"}, cmd_ready, 1);
        for (int t = 1; t <= v.done_at + 1; t++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            abort = (t == abort_t);
            @(negedge clk);
            want_step = (kexp <= issued) && (t == t_step[kexp]);
            if (step !== want_step) e_step++;
            if (step === 1'b1) nsteps++;
            if (busy !== (t < v.done_at)) e_busy++;
            if (done !== (t == v.done_at)) e_done++;
            if (cmd_ready !== (t == v.done_at + 1)) e_rdy++;
            if (dir !== v.d) e_dir++;
            if (position !== model) e_pos++;
            if (want_step) begin
                model = v.d ? model + 16'd1 : model - 16'd1;
                kexp++;
            end
        end
        abort = 1'b0;
        check({tag, ":step_timing_errs"}, e_step, 0);
        check({tag, ":step_count"}, nsteps, issued);
        check({tag, ":busy_errs"}, e_busy, 0);
        check({tag, ":done_errs"}, e_done, 0);
        check({tag, ":ready_errs"}, e_rdy, 0);
        check({tag, ":dir_errs"}, e_dir, 0);
        check({tag, ":pos_track_errs"}, e_pos, 0);
        check({tag, ":position"}, position, v.pos_after);
        exp_pos = v.pos_after;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_t;
        int nsteps;
        int cyc;
        vec_t v;

        tbl[0] = '{1'b1, 10, 0, 16'd10,   RAMP ? 61 : 21};
        tbl[1] = '{1'b0, 5,  0, 16'd5,    RAMP ? 43 : 11};
        tbl[2] = '{1'b1, 10, 3, 16'd7,    RAMP ? 25 : 7};
        tbl[3] = '{1'b0, 0,  0, 16'd7,    1};
        tbl[4] = '{1'b0, 9,  0, 16'hFFFE, RAMP ? 59 : 19};
        tbl[5] = '{1'b1, 2,  0, 16'd0,    RAMP ? 21 : 5};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = 16'd0; abort = 1'b0;
        #3;
        check("rst:cmd_ready", cmd_ready, 1);
        check("rst:step", step, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:dir", dir, 0);
        check("rst:position", position, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_move(tbl[i], $sformatf("vec%0d", i));

        // Command held valid during a move is accepted exactly at S+2.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd2;
        @(negedge clk);
        check("hold:first_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_steps = 16'd0;
        acc_t = -1;
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                acc_t = t;
                break;
            end
            @(posedge clk); #1;
        end
        check("hold:accept_cycle", acc_t, RAMP ? 22 : 6);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("hold:zero_len_done", done, 1);
        check("hold:zero_len_step", step, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold:ready_again", cmd_ready, 1);
        check("hold:position", position, 16'd2);

        // Abort while idle has no effect.
        @(posedge clk); #1; abort = 1'b1;
        @(negedge clk);
        check("idle_abort:done", done, 0);
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("idle_abort:ready", cmd_ready, 1);
        check("idle_abort:busy", busy, 0);

        // Reset in the middle of a move.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid_rst:busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst:position", position, 0);
        check("mid_rst:busy", busy, 0);
        check("mid_rst:dir", dir, 0);
        check("mid_rst:step", step, 0);
        check("mid_rst:done", done, 0);
        check("mid_rst:ready", cmd_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        nsteps = 0;
        repeat (40) begin
            @(negedge clk);
            if (step !== 1'b0) nsteps++;
        end
        check("mid_rst:steps_after_release", nsteps, 0);
        exp_pos = 16'd0;

        // Long forward move up to 0x7FFF, then one step across the sign boundary.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd32767;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        nsteps = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 70000) begin
            @(negedge clk);
            if (step === 1'b1) nsteps++;
            cyc++;
        end
        check("long:done_seen", done, 1);
        check("long:steps", nsteps, 32767);
        @(negedge clk);
        check("long:position", position, 16'h7FFF);
        exp_pos = 16'h7FFF;
        v = '{1'b1, 1, 0, 16'h8000, RAMP ? 11 : 3};
        run_move(v, "wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
